conv_block_sequencer: RTL
=========================

Name: conv_block_sequencer

Overview:
Multi-bank address/control sequencer for the 2D convolution datapath. It generalises the single-convolver load/process/readback FSM to N_CONV convolver banks. It adds latched image length, one-hot bank write enables, a result write enable aligned to convolver latency, and a command-error flag. It sits between the host-side load/valid interface and the line memories and convolver array.

Parameters:
NB_ADDRESS, 10, memory address width
NB_IMAGE, 10, image-length field width
N_CONV, 4, number of convolver banks (≥1)
NB_BANK, 2, bank index width; 2^NB_BANK ≥ N_CONV
LATENCIA, 5, convolver pipeline latency in cycles (≥1)

Ports:
i_CLK  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_imgLength  in  NB_IMAGE  words per block; latched on leaving IDLE
i_load  in  1  load command
i_SoP  in  1  start-of-process command
i_valid  in  1  host data strobe; rising edge = one word
o_readAdd  out  NB_ADDRESS  memory read address
o_writeAdd  out  NB_ADDRESS  memory write address
o_bank  out  NB_BANK  active bank index
o_bankWe  out  N_CONV  one-hot load write enable
o_resWe  out  1  convolver result write enable
o_convVld  out  1  convolver input valid
o_sopross  out  1  high while in PROC
o_changeBlock  out  1  1-cycle pulse at end of each block
o_EoP  out  1  high while readback blocks are pending
o_cmdErr  out  1  1-cycle pulse on illegal command
o_state  out  3  current state code

Behaviour:
- Reset: every output is 0. State is IDLE, all counters are 0, pending=0, bank=0, and the valid edge register is 0. Reset mid-operation aborts the operation on the next edge and clears pending.
- Edge detect: vedge = i_valid & ~valid_q. valid_q is registered every cycle.
- States: IDLE=000, LOAD=001, PROC=010, DONE=011, READ=100.
- IDLE: addresses are held at 0. Command priority:
  - (a) i_load & i_SoP, or any command while len_q<2 → o_cmdErr pulse, stay in IDLE.
  - (b) ~i_load & ~i_SoP & pending>0 → READ.
  - (c) i_load & pending==0 → LOAD, bank=0.
  - (d) i_SoP & pending==0 → PROC.
  - A command issued while pending>0 → o_cmdErr, stay in IDLE.
  - i_imgLength is latched into len_q on every transition out of IDLE.
- LOAD: on each vedge, o_bankWe[bank]=1 for exactly one cycle with o_writeAdd=cnt, then cnt++.
  - At cnt==len_q-1: cnt→0 and bank++.
  - After the write of the last word of bank N_CONV-1: o_changeBlock pulses, bank→0, go to IDLE.
  - A load therefore writes N_CONV×len_q words.
- PROC:
  - o_readAdd=cnt; cnt increments each cycle, saturating at len_q-1.
  - o_convVld is 1 from the first PROC cycle through the cycle cnt==len_q-1.
  - o_resWe goes high exactly LATENCIA cycles after PROC entry and stays high for len_q cycles. o_writeAdd=wcnt increments 0..len_q-1 while o_resWe is high.
  - On the wcnt==len_q-1 write: o_changeBlock pulses, pending←N_CONV, go to DONE.
  - Total PROC duration is len_q+LATENCIA cycles.
- DONE: stay while i_SoP=1; go to IDLE when i_SoP=0.
- READ:
  - On each vedge, o_readAdd=cnt, o_bank=bank, then cnt++.
  - At cnt==len_q-1: cnt→0, pending--, o_changeBlock pulses, go to IDLE.
  - bank++ on each block; bank→0 when pending reaches 0.
- o_EoP = (pending≠0).
- o_sopross = (state==PROC).
- o_writeAdd equals wcnt in PROC and cnt otherwise.
- Widths: counters are NB_ADDRESS bits. len_q is zero-extended or truncated to NB_ADDRESS. len_q-1 is computed in NB_ADDRESS bits.

Optional Feature:
Macro CONV_SEQ_AUTOREAD_EN.
- Defined: DONE with i_SoP=0 goes directly to READ. READ drains all N_CONV blocks back-to-back with no IDLE re-entry: o_changeBlock pulses per block, and the FSM returns to IDLE only when pending reaches 0.
- Undefined: the behaviour above; each readback block requires IDLE re-entry with ~i_load & ~i_SoP.

Test Plan:
1. Load: N_CONV=4, len=8, 32 valid pulses → o_bankWe walks 0001→0010→0100→1000, 8 writes each at addresses 0..7; single o_changeBlock after the 32nd write; state returns to 000.
2. Process: len=8, LATENCIA=5, i_SoP held → o_convVld high 8 cycles; o_resWe high on cycles 5..12 after entry with o_writeAdd 0..7; o_EoP=1 and state=011 afterwards; i_SoP low → IDLE.
3. Readback: after test 2, 4 commands of 8 valid edges each → o_bank 0,1,2,3; 4 o_changeBlock pulses; o_EoP falls after the 4th block; a held-high i_valid counts once.
4. Errors: i_load=i_SoP=1, and i_SoP while pending=2, and len=1 → o_cmdErr pulse each time, state stays 000.
5. Reset: i_reset asserted mid-LOAD (bank 2, cnt 5) and mid-PROC → next cycle all outputs 0, pending 0, state 000.
6. With CONV_SEQ_AUTOREAD_EN defined, N_CONV=2, len=4: after PROC, i_SoP low plus 8 valid edges → 2 changeBlock pulses, no IDLE between blocks, then IDLE.

Source files
------------

// File: rtl/conv_block_sequencer.sv
// Multi-bank load/process/readback address and control sequencer for the convolver array.
// Optional CONV_SEQ_AUTOREAD_EN: drain all readback blocks back-to-back without returning to IDLE.
module conv_block_sequencer #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_IMAGE   = 10,
    parameter int N_CONV     = 4,
    parameter int NB_BANK    = 2,
    parameter int LATENCIA   = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_reset,
    input  logic [NB_IMAGE-1:0]   i_imgLength,
    input  logic                  i_load,
    input  logic                  i_SoP,
    input  logic                  i_valid,
    output logic [NB_ADDRESS-1:0] o_readAdd,
    output logic [NB_ADDRESS-1:0] o_writeAdd,
    output logic [NB_BANK-1:0]    o_bank,
    output logic [N_CONV-1:0]     o_bankWe,
    output logic                  o_resWe,
    output logic                  o_convVld,
    output logic                  o_sopross,
    output logic                  o_changeBlock,
    output logic                  o_EoP,
    output logic                  o_cmdErr,
    output logic [2:0]            o_state
);
    localparam int NB_PEND = $clog2(N_CONV + 1);
    localparam int NB_LAT  = $clog2(LATENCIA + 1);
    localparam logic [NB_ADDRESS-1:0] ONE_A  = 1;
    localparam logic [NB_ADDRESS-1:0] TWO_A  = 2;
    localparam logic [NB_BANK-1:0]    ONE_B  = 1;
    localparam logic [NB_BANK-1:0]    LAST_B = NB_BANK'(N_CONV - 1);
    localparam logic [NB_PEND-1:0]    ONE_P  = 1;
    localparam logic [NB_PEND-1:0]    FULL_P = NB_PEND'(N_CONV);
    localparam logic [NB_LAT-1:0]     ONE_L  = 1;
    localparam logic [NB_LAT-1:0]     LAT_L  = NB_LAT'(LATENCIA);
    localparam logic [N_CONV-1:0]     WE_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_PROC = 3'b010,
        S_DONE = 3'b011,
        S_READ = 3'b100
    } state_t;

    state_t                state_q, state_d;
    logic [NB_ADDRESS-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d, len_q, len_d;
    logic [NB_BANK-1:0]    bank_q, bank_d;
    logic [NB_PEND-1:0]    pend_q, pend_d;
    logic [NB_LAT-1:0]     lat_q, lat_d;
    logic                  rd_done_q, rd_done_d;
    logic                  valid_q;
    logic                  vedge, cmd;
    logic [NB_ADDRESS-1:0] len_in, len_m1;

    assign vedge  = i_valid & ~valid_q;
    assign cmd    = i_load | i_SoP;
    assign len_in = NB_ADDRESS'(i_imgLength);
    assign len_m1 = len_q - ONE_A;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wcnt_d        = wcnt_q;
        len_d         = len_q;
        bank_d        = bank_q;
        pend_d        = pend_q;
        lat_d         = lat_q;
        rd_done_d     = rd_done_q;
        o_readAdd     = '0;
        o_writeAdd    = cnt_q;
        o_bank        = bank_q;
        o_bankWe      = '0;
        o_resWe       = 1'b0;
        o_convVld     = 1'b0;
        o_changeBlock = 1'b0;
        o_cmdErr      = 1'b0;
        o_sopross     = (state_q == S_PROC);
        o_EoP         = (pend_q != '0);
        o_state       = state_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                wcnt_d    = '0;
                lat_d     = '0;
                rd_done_d = 1'b0;
                // The length checked is the one that would be latched by this command.
                if ((i_load && i_SoP) || (cmd && len_in < TWO_A) || (cmd && pend_q != '0)) begin
                    o_cmdErr = 1'b1;
                end else if (!cmd && pend_q != '0) begin
                    state_d = S_READ;
                    len_d   = len_in;
                end else if (i_load) begin
                    state_d = S_LOAD;
                    bank_d  = '0;
                    len_d   = len_in;
                end else if (i_SoP) begin
                    state_d = S_PROC;
                    len_d   = len_in;
                end
            end
            S_LOAD: begin
                if (vedge) begin
                    o_bankWe = WE_ONE << bank_q;
                    if (cnt_q == len_m1) begin
                        cnt_d = '0;
                        if (bank_q == LAST_B) begin
                            o_changeBlock = 1'b1;
                            bank_d        = '0;
                            state_d       = S_IDLE;
                        end else begin
                            bank_d = bank_q + ONE_B;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE_A;
                    end
                end
            end
            S_PROC: begin
                o_readAdd  = cnt_q;
                o_writeAdd = wcnt_q;
                o_convVld  = ~rd_done_q;
                if (cnt_q == len_m1) rd_done_d = 1'b1;
                else                 cnt_d = cnt_q + ONE_A;
                // Results start emerging once the pipeline latency has elapsed.
                if (lat_q != LAT_L) begin
                    lat_d = lat_q + ONE_L;
                end else begin
                    o_resWe = 1'b1;
                    if (wcnt_q == len_m1) begin
                        o_changeBlock = 1'b1;
                        pend_d        = FULL_P;
                        cnt_d         = '0;
                        wcnt_d        = '0;
                        state_d       = S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + ONE_A;
                    end
                end
            end
            S_DONE: begin
                if (!i_SoP) begin
`ifdef CONV_SEQ_AUTOREAD_EN
                    state_d = S_READ;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_READ: begin
                o_readAdd = cnt_q;
                if (vedge) begin
                    if (cnt_q == len_m1) begin
                        cnt_d         = '0;
                        pend_d        = pend_q - ONE_P;
                        o_changeBlock = 1'b1;
                        if (pend_q == ONE_P) begin
                            bank_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            bank_d = bank_q + ONE_B;
`ifdef CONV_SEQ_AUTOREAD_EN
                            state_d = S_READ;
`else
                            state_d = S_IDLE;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + ONE_A;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            len_q     <= '0;
            bank_q    <= '0;
            pend_q    <= '0;
            lat_q     <= '0;
            rd_done_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            len_q     <= len_d;
            bank_q    <= bank_d;
            pend_q    <= pend_d;
            lat_q     <= lat_d;
            rd_done_q <= rd_done_d;
            valid_q   <= i_valid;
        end
    end
endmodule
